// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared CPU definitions used by the instruction fetch unit: machine word
//   width, the reset vector and the fetch-state encodings, plus the PC
//   next-value rule (load beats increment, increment wraps modulo 2^16).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_VECTOR = 16'h0000;

    // S_REQ   : a request for the current pc is outstanding (or about to be
    //           issued, straight after reset)
    // S_VALID : i_bus holds the word at pc
    // S_DROP  : the outstanding request is stale; a request for the new pc
    //           goes out once the old one completes
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

    // Next program counter. A load takes priority over an increment issued
    // in the same cycle; the increment wraps 0xFFFF -> 0x0000.
    function automatic word_t next_pc(input word_t pc,
                                      input logic  load,
                                      input logic  inc,
                                      input word_t target);
        if (load) begin
            return target;
        end
        if (inc) begin
            return pc + word_t'(1);
        end
        return pc;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Holds the architectural program counter and keeps i_bus loaded with the
//   instruction word at pc by issuing single outstanding reads to the
//   instruction memory. Requests are never altered while outstanding, so a
//   pc change during a request waits for that request to complete, throws
//   its data away, then re-requests the new pc.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   pc_increment one-cycle strobe: pc <= pc + 1
//   pc_load      one-cycle strobe: pc <= d_bus (wins over pc_increment)
//   d_bus        jump target
//   i_bus        registered instruction word
//   i_valid      registered; i_bus equals the word at pc
//   pc           architectural program counter
//   imem_req     read request, held until imem_ack
//   imem_addr    read address, stable while imem_req is high
//   imem_data    read data, valid in the imem_ack cycle
//   imem_ack     one-cycle completion of the outstanding request
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_increment,
    input  logic              pc_load,
    input  logic [WORD_W-1:0] d_bus,
    output logic [WORD_W-1:0] i_bus,
    output logic              i_valid,
    output logic [WORD_W-1:0] pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              imem_ack
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        i_bus_q, i_bus_d;
    word_t        imem_addr_q, imem_addr_d;
    logic         i_valid_q, i_valid_d;
    logic         imem_req_q, imem_req_d;

    logic         pc_update;
    logic         ack_accepted;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        pc_update    = pc_load | pc_increment;
        pc_d         = next_pc(pc_q, pc_load, pc_increment, d_bus);
        // An ack with no request outstanding is meaningless and ignored.
        ack_accepted = imem_req_q & imem_ack;

        state_d      = state_q;
        i_bus_d      = i_bus_q;
        i_valid_d    = i_valid_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;

        case (state_q)
            S_REQ: begin
                if (!imem_req_q) begin
                    // Straight out of reset: no request yet, issue one for pc.
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_d;
                end else if (ack_accepted && pc_update) begin
                    // Data belongs to the old pc; request the new one at once.
                    imem_addr_d = pc_d;
                end else if (ack_accepted) begin
                    i_bus_d    = imem_data;
                    i_valid_d  = 1'b1;
                    imem_req_d = 1'b0;
                    state_d    = S_VALID;
                end else if (pc_update) begin
                    // Request must stay untouched until its ack arrives.
                    state_d = S_DROP;
                end
            end

            S_VALID: begin
                if (pc_update) begin
                    // i_bus keeps the old word; i_valid flags it as stale.
                    i_valid_d   = 1'b0;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_d;
                    state_d     = S_REQ;
                end
            end

            S_DROP: begin
                if (ack_accepted) begin
                    // Discard the stale data; pc_d already folds in any
                    // update arriving in this same cycle.
                    imem_addr_d = pc_d;
                    state_d     = S_REQ;
                end
            end

            default: begin
                // Unreachable encoding: treat any outstanding request as
                // stale so its data can never reach i_bus.
                i_valid_d = 1'b0;
                state_d   = imem_req_q ? S_DROP : S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_VECTOR;
            i_bus_q     <= '0;
            i_valid_q   <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_VECTOR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            i_bus_q     <= i_bus_d;
            i_valid_q   <= i_valid_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign i_bus     = i_bus_q;
    assign i_valid   = i_valid_q;
    assign pc        = pc_q;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed scenarios for the documented corner cases, then a randomized
//   run checked against a transaction-level model: an arithmetic PC, an
//   instruction memory given by a fixed bijective function, and the
//   externally visible fetch rules (request stability, fresh-address
//   requests, delivery only of the word at pc).
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_increment;
    logic        pc_load;
    logic [15:0] d_bus;
    logic [15:0] i_bus;
    logic        i_valid;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_ack;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_increment (pc_increment),
        .pc_load      (pc_load),
        .d_bus        (d_bus),
        .i_bus        (i_bus),
        .i_valid      (i_valid),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_ack     (imem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: odd multiplier makes it a bijection, so
    // every address holds a distinct word and stale data is detectable.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'h9E37;
        return m ^ 16'h5A3C;
    endfunction

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_increment = 1'b0;
        pc_load      = 1'b0;
        d_bus        = 16'h0000;
        imem_ack     = 1'b0;
        imem_data    = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus, take the edge, return inputs to idle.
    task automatic cycle_with(input logic ld, input logic inc, input logic [15:0] d,
                              input logic ack, input logic [15:0] data);
        pc_load      = ld;
        pc_increment = inc;
        d_bus        = d;
        imem_ack     = ack;
        imem_data    = data;
        step();
        idle_inputs();
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] ib,
                              input logic [15:0] p, input logic rq, input logic [15:0] ad);
        check({tag, ".i_valid"},   i_valid,   v);
        check({tag, ".i_bus"},     i_bus,     ib);
        check({tag, ".pc"},        pc,        p);
        check({tag, ".imem_req"},  imem_req,  rq);
        check({tag, ".imem_addr"}, imem_addr, ad);
    endtask

    // Watchdog: the bench has no open-ended waits, but never hang regardless.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] model_pc;
        logic [15:0] pre_addr;
        logic        pre_req, pre_valid, accepted, upd, rst_now, dirty, dirty_pre, after_rst;

        rst = 1'b1;
        idle_inputs();

        // ---------------- directed scenarios ----------------
        do_reset();
        expect_out("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step();
        expect_out("first_req", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'hF10A);
        expect_out("first_fetch", 1'b1, 16'hF10A, 16'h0000, 1'b0, 16'h0000);

        // Increment from S_VALID, ack delayed 3 cycles.
        cycle_with(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
        expect_out("inc_req", 1'b0, 16'hF10A, 16'h0001, 1'b1, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            check("slow_ack.addr_stable", imem_addr, 16'h0001);
            check("slow_ack.no_valid", i_valid, 1'b0);
            if (k == 3) cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
            else        step();
        end
        expect_out("slow_ack_done", 1'b1, 16'h1234, 16'h0001, 1'b0, 16'h0001);

        // Jump while a request to 0x0005 is outstanding; stale 0xDEAD dropped.
        cycle_with(1'b1, 1'b0, 16'h0005, 1'b0, 16'h0000);
        expect_out("load5", 1'b0, 16'h1234, 16'h0005, 1'b1, 16'h0005);
        cycle_with(1'b1, 1'b0, 16'h0040, 1'b0, 16'h0000);
        expect_out("drop_load", 1'b0, 16'h1234, 16'h0040, 1'b1, 16'h0005);
        step();
        expect_out("drop_wait", 1'b0, 16'h1234, 16'h0040, 1'b1, 16'h0005);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
        expect_out("drop_ack", 1'b0, 16'h1234, 16'h0040, 1'b1, 16'h0040);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
        expect_out("drop_refetch", 1'b1, 16'hBEEF, 16'h0040, 1'b0, 16'h0040);

        // Wrap 0xFFFF -> 0x0000.
        cycle_with(1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        expect_out("at_ffff", 1'b1, 16'h7777, 16'hFFFF, 1'b0, 16'hFFFF);
        cycle_with(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
        expect_out("wrap", 1'b0, 16'h7777, 16'h0000, 1'b1, 16'h0000);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A0A);

        // Load and increment together: load wins.
        cycle_with(1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000);
        expect_out("load_wins", 1'b0, 16'h0A0A, 16'h0100, 1'b1, 16'h0100);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'hC0DE);

        // Update coinciding with ack in S_REQ: data discarded, new request.
        cycle_with(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
        cycle_with(1'b0, 1'b1, 16'h0000, 1'b1, 16'h5555);
        expect_out("upd_with_ack", 1'b0, 16'hC0DE, 16'h0102, 1'b1, 16'h0102);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666);
        expect_out("upd_with_ack_done", 1'b1, 16'h6666, 16'h0102, 1'b0, 16'h0102);

        // Reset during an outstanding request, with ack and load in the rst cycle.
        cycle_with(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
        rst = 1'b1;
        cycle_with(1'b1, 1'b0, 16'h3333, 1'b1, 16'h9999);
        rst = 1'b0;
        expect_out("rst_mid_req", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step();
        expect_out("rst_reissue", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        cycle_with(1'b0, 1'b0, 16'h0000, 1'b1, 16'hAAAA);
        expect_out("rst_refetch", 1'b1, 16'hAAAA, 16'h0000, 1'b0, 16'h0000);

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_pc  = RESET_VECTOR;
        dirty     = 1'b0;
        after_rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_now = ($urandom_range(0, 399) == 0);
            rst     = rst_now;
            if (after_rst) begin
                pc_load      = 1'b0;
                pc_increment = 1'b0;
            end else begin
                pc_load      = ($urandom_range(0, 99) < 8);
                pc_increment = ($urandom_range(0, 99) < 15);
            end
            d_bus     = 16'($urandom);
            imem_ack  = ($urandom_range(0, 99) < 40);
            imem_data = (imem_req && imem_ack) ? mem_word(imem_addr) : 16'($urandom);

            pre_req   = imem_req;
            pre_addr  = imem_addr;
            pre_valid = i_valid;
            upd       = pc_load | pc_increment;
            accepted  = pre_req & imem_ack & ~rst_now;
            dirty_pre = dirty;
            if (rst_now)           model_pc = RESET_VECTOR;
            else if (pc_load)      model_pc = d_bus;
            else if (pc_increment) model_pc = model_pc + 16'd1;

            step();

            check("rnd_pc", pc, model_pc);
            if (rst_now) begin
                check("rnd_rst_req", imem_req, 1'b0);
                check("rnd_rst_valid", i_valid, 1'b0);
                check("rnd_rst_ibus", i_bus, 16'h0000);
                check("rnd_rst_addr", imem_addr, 16'h0000);
                dirty     = 1'b0;
                after_rst = 1'b1;
            end else begin
                after_rst = 1'b0;
                check("rnd_req_vs_valid", imem_req, !i_valid);
                if (pre_req && !accepted) begin
                    check("rnd_req_held", imem_req, 1'b1);
                    check("rnd_addr_stable", imem_addr, pre_addr);
                end
                if (imem_req && (!pre_req || accepted)) begin
                    check("rnd_new_req_addr", imem_addr, model_pc);
                    dirty = 1'b0;
                end else if (upd) begin
                    dirty = 1'b1;
                end
                if (upd)
                    check("rnd_upd_clears_valid", i_valid, 1'b0);
                if (i_valid)
                    check("rnd_ibus_word", i_bus, mem_word(pc));
                if (i_valid && !pre_valid)
                    check("rnd_valid_needs_ack", accepted, 1'b1);
                if (accepted && !upd && !dirty_pre)
                    check("rnd_deliver", i_valid, 1'b1);
            end
        end

        idle_inputs();
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 pc_increment  input  1  one-cycle strobe from control unit; advance PC by 1.
REQ-004 pc_load  input  1  one-cycle strobe from control unit; load PC from d_bus.
REQ-005 d_bus  input  16  jump target, sampled only when pc_load=1.
REQ-006 i_bus  output  16  instruction word at pc; registered.
REQ-007 i_valid  output  1  i_bus holds mem[pc]; registered.
REQ-008 pc  output  16  architectural program counter.
REQ-009 imem_req  output  1  instruction-memory read request; held high until imem_ack.
REQ-010 imem_addr  output  16  read address; stable while imem_req=1.
REQ-011 imem_data  input  16  read data, valid in the imem_ack cycle.
REQ-012 imem_ack  input  1  one-cycle completion of the outstanding request; may arrive in the first imem_req cycle or any later one.

Function
REQ-013 States: S_REQ (request for pc outstanding), S_VALID (i_bus=mem[pc]), S_DROP (stale request outstanding; new pc pending).
REQ-014 PC update: pc_load -> pc<=d_bus; else pc_increment -> pc<=pc+1, mod 2^16 (0xFFFF wraps to 0x0000).
REQ-015 pc_load and pc_increment in the same cycle: load wins; increment ignored.
REQ-016 S_VALID, PC update: i_valid<=0; i_bus holds the old word; imem_req<=1 with imem_addr=new pc; -> S_REQ.
REQ-017 S_REQ, imem_ack, no PC update: i_bus<=imem_data; i_valid<=1; imem_req<=0; -> S_VALID.
REQ-018 S_REQ, PC update, no ack: imem_req and imem_addr unchanged; -> S_DROP.
REQ-019 S_REQ, PC update with imem_ack in the same cycle: discard data; new request for new pc next cycle; stay in S_REQ.
REQ-020 S_DROP, imem_ack: discard data; next cycle imem_req=1, imem_addr=current pc (including any update this cycle); -> S_REQ.
REQ-021 S_DROP, PC update without ack: pc updates; stay in S_DROP.
REQ-022 imem_addr and imem_req never change while a request is outstanding, except on rst.
REQ-023 imem_ack while imem_req=0: ignored.
REQ-024 Minimum latency: strobe at edge N -> imem_req high in cycle N+1 -> with same-cycle ack, i_valid=1 in cycle N+2.
REQ-025 i_valid=1 only when i_bus equals the word at address pc; no stale or discarded data ever reaches i_bus.

Reset
REQ-026 rst=1 at a clock edge: pc=0x0000, i_bus=0x0000, i_valid=0, imem_req=0, imem_addr=0x0000, state S_REQ with no request issued.
REQ-027 First cycle after rst deasserts: imem_req=1, imem_addr=0x0000.
REQ-028 rst during an outstanding request abandons it; an ack arriving while rst=1 is ignored.
REQ-029 rst has priority over pc_load and pc_increment.

Structure
REQ-030 The shared CPU package holds the word width (16), the reset vector (0x0000) and the fetch-state encodings.
REQ-031 Single module with no sub-modules; the PC and the request-address register are separate registers.

Verification
REQ-032 Reset, ack on the first request cycle with data 0xF10A -> cycle 2: i_valid=1, i_bus=0xF10A, pc=0x0000.
REQ-033 In S_VALID, pc_increment; ack delayed 3 cycles -> imem_addr=0x0001 stable for 4 cycles; i_valid=0 throughout; then i_valid=1 with new data.
REQ-034 In S_REQ (addr 0x0005, no ack), pc_load with d_bus=0x0040; ack 2 cycles later with 0xDEAD -> 0xDEAD never on i_bus; next request addr=0x0040; pc=0x0040.
REQ-035 pc=0xFFFF, pc_increment -> pc=0x0000, imem_addr=0x0000.
REQ-036 pc_load (d_bus=0x0100) and pc_increment in the same cycle -> pc=0x0100.
REQ-037 rst during an outstanding request, with an ack in the rst cycle -> outputs at reset values; a fresh request to 0x0000 is issued one cycle after rst deasserts.
